freq_gate_counter: RTL and testbench

//  Gated frequency counter that measures the Fxin test signal from the signal generator.

---
 rtl/freq_gate_counter_pkg.sv | 31 +++
 rtl/freq_gate_counter_bin2bcd.sv | 75 +++++++
 rtl/freq_gate_counter.sv | 168 ++++++++++++++++
 tb/tb_freq_gate_counter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gate_counter_pkg.sv
// Shared types and constants for the gated frequency counter.
// Holds FSM encodings, BCD sizing and the double-dabble digit correction.
package freq_gate_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        CONVERT = 2'd2,
        UPDATE  = 2'd3
    } state_e;

    localparam int DEF_BCD_MAX = 9999;
    localparam int BCD_DIGITS  = 4;
    localparam int BCD_W       = 4 * BCD_DIGITS;

    // Consecutive enabled IDLE cycles before a gate may open.
    localparam int IDLE_FLUSH  = 3;

    // Add 3 to every digit that is 5 or more, ahead of the next shift.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_gate_counter_bin2bcd.sv
// Iterative double-dabble converter: one bit per clock, CNT_W clocks per result.
// start loads the operand, done pulses once when bcd_out holds the result.
module freq_gate_counter_bin2bcd
    import freq_gate_counter_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam int ITER_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(CNT_W - 1);

    logic [CNT_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  corr;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Load on start, otherwise correct-and-shift one bit while busy.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        corr   = dabble_step(bcd_q);
        if (clr) begin
            busy_d = 1'b0;
            iter_d = '0;
        end else if (start) begin
            bin_d  = bin_in;
            bcd_d  = '0;
            iter_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, bin_d} = {corr, bin_q} << 1;
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts Fxin rising edges over a fixed window of
// Clk cycles and publishes the count as 4-digit packed BCD.
module freq_gate_counter
    import freq_gate_counter_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 14,
    parameter int BCD_MAX     = DEF_BCD_MAX
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic        Fxin,
    output logic [15:0] Frequency,
    output logic        Valid,
    output logic        Overflow
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int CONV_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CNT_W - 1);
    localparam logic [1:0]        IDLE_LAST = 2'(IDLE_FLUSH - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
    localparam logic [CNT_W-1:0]  CNT_CLAMP = CNT_W'(BCD_MAX);

    logic s1_q, s2_q, s3_q;
    logic rise;

    state_e             state_q, state_d;
    logic [1:0]         idle_cnt_q, idle_cnt_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [CONV_W-1:0]  conv_cnt_q, conv_cnt_d;
    logic               meas_ovf_q, meas_ovf_d;
    logic [BCD_W-1:0]   freq_q, freq_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [CNT_W-1:0]   edge_inc;
    logic [CNT_W-1:0]   conv_val;
    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    // Two-flop synchroniser plus delay flop for edge detection, always running.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= Fxin;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Next-state logic: gate timing, edge counting and result capture.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        conv_cnt_d = conv_cnt_q;
        meas_ovf_d = meas_ovf_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        conv_start = 1'b0;
        edge_inc   = (rise && edge_cnt_q != CNT_SAT)
                   ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        conv_val   = (edge_inc > CNT_CLAMP) ? CNT_CLAMP : edge_inc;
        if (!En) begin
            state_d    = IDLE;
            idle_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = GATE;
                        idle_cnt_d = '0;
                        gate_cnt_d = '0;
                        edge_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 2'd1;
                    end
                end
                GATE: begin
                    edge_cnt_d = edge_inc;
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d    = CONVERT;
                        conv_start = !conv_busy;
                        conv_cnt_d = '0;
                        meas_ovf_d = (edge_inc > CNT_CLAMP);
                    end else begin
                        gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    end
                end
                CONVERT: begin
                    if (conv_cnt_q == CONV_LAST) begin
                        state_d = UPDATE;
                    end else begin
                        conv_cnt_d = conv_cnt_q + CONV_W'(1);
                    end
                end
                UPDATE: begin
                    if (conv_done) begin
                        freq_d  = conv_bcd;
                        ovf_d   = meas_ovf_q;
                        valid_d = 1'b1;
                    end
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            conv_cnt_q <= '0;
            meas_ovf_q <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            conv_cnt_q <= conv_cnt_d;
            meas_ovf_q <= meas_ovf_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    freq_gate_counter_bin2bcd #(
        .CNT_W (CNT_W)
    ) u_bin2bcd (
        .clk     (Clk),
        .rst     (Rst),
        .clr     (~En),
        .start   (conv_start),
        .bin_in  (conv_val),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign Frequency = freq_q;
    assign Overflow  = ovf_q;
    assign Valid     = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter: short-gate and long-gate instances
// share one clock; a monitor checks every Valid against queued expectations.
module tb_freq_gate_counter;

    localparam int CNT_W = 14;
    localparam int G1    = 1000;
    localparam int G2    = 30000;
    localparam int PER1  = G1 + CNT_W + 1;
    localparam int LAT1  = 3 + G1 + CNT_W + 1;

    typedef struct packed {
        logic [15:0] f;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, en1, fx1, val1, ovf1;
    logic [15:0] freq1;
    logic        rst2, en2, fx2, val2, ovf2;
    logic [15:0] freq2;

    int   ph = 0;
    int   pcnt = 0;
    int   fx1_per = 0;
    int   fx2_per = 0;
    logic fx1_hold = 1'b0;
    logic fx2_hold = 1'b0;

    exp_t q1[$];
    exp_t q2[$];
    int   vt1[$];
    int   nval1 = 0;
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) ph <= ph + 1;
    always @(posedge clk) pcnt <= pcnt + 1;

    assign fx1 = (fx1_per == 0) ? fx1_hold : ((ph % fx1_per) < (fx1_per / 2));
    assign fx2 = (fx2_per == 0) ? fx2_hold : ((ph % fx2_per) < (fx2_per / 2));

    freq_gate_counter #(
        .GATE_CYCLES (G1),
        .CNT_W       (CNT_W),
        .BCD_MAX     (9999)
    ) dut1 (
        .Clk       (clk),
        .Rst       (rst1),
        .En        (en1),
        .Fxin      (fx1),
        .Frequency (freq1),
        .Valid     (val1),
        .Overflow  (ovf1)
    );

    freq_gate_counter #(
        .GATE_CYCLES (G2),
        .CNT_W       (CNT_W),
        .BCD_MAX     (9999)
    ) dut2 (
        .Clk       (clk),
        .Rst       (rst2),
        .En        (en2),
        .Fxin      (fx2),
        .Frequency (freq2),
        .Valid     (val2),
        .Overflow  (ovf2)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic push(input int which, input logic [15:0] f, input logic o, input int n);
        exp_t e;
        e.f = f;
        e.o = o;
        for (int i = 0; i < n; i++) begin
            if (which == 1) q1.push_back(e);
            else q2.push_back(e);
        end
    endtask

    task automatic drain(input int which, input int budget);
        int k;
        int left;
        k = 0;
        left = (which == 1) ? q1.size() : q2.size();
        while (left != 0 && k < budget) begin
            @(posedge clk);
            k++;
            left = (which == 1) ? q1.size() : q2.size();
        end
        n_tests++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL dut%0d_timeout got %0d pending expected 0 after %0d cycles",
                     which, left, budget);
            if (which == 1) q1.delete();
            else q2.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: pop and compare on every Valid, and check Valid spacing.
    always @(negedge clk) begin
        exp_t e;
        if (val1) begin
            vt1.push_back(pcnt);
            nval1++;
            check("dut1_valid_gap", int'(pv1), 0);
            if (q1.size() == 0) begin
                check("dut1_unexpected_valid", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut1_freq", int'(freq1), int'(e.f));
                check("dut1_ovf", int'(ovf1), int'(e.o));
            end
        end
        if (val2) begin
            check("dut2_valid_gap", int'(pv2), 0);
            if (q2.size() == 0) begin
                check("dut2_unexpected_valid", 1, 0);
            end else begin
                e = q2.pop_front();
                check("dut2_freq", int'(freq2), int'(e.f));
                check("dut2_ovf", int'(ovf2), int'(e.o));
            end
        end
        pv1 = val1;
        pv2 = val2;
    end

    task automatic run_dut1();
        int t0;
        int nv;
        rst1 = 1'b1;
        en1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_freq", int'(freq1), 0);
        check("rst_valid", int'(val1), 0);
        check("rst_ovf", int'(ovf1), 0);
        rst1 = 1'b0;

        // Period 10 -> 100 edges per gate, steady cadence.
        fx1_per = 10;
        vt1.delete();
        en1 = 1'b1;
        push(1, 16'h0100, 1'b0, 3);
        drain(1, 4 * PER1 + 100);
        en1 = 1'b0;
        check("t1_valid_count", vt1.size(), 3);
        if (vt1.size() >= 3) begin
            check("t1_interval_a", vt1[1] - vt1[0], PER1);
            check("t1_interval_b", vt1[2] - vt1[1], PER1);
        end

        // Fxin held low, then held high straight out of reset.
        fx1_per = 0;
        fx1_hold = 1'b0;
        repeat (2) @(negedge clk);
        en1 = 1'b1;
        push(1, 16'h0000, 1'b0, 2);
        drain(1, 3 * PER1 + 100);
        en1 = 1'b0;
        fx1_hold = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        en1 = 1'b1;
        push(1, 16'h0000, 1'b0, 2);
        drain(1, 3 * PER1 + 100);
        en1 = 1'b0;

        // Toggle every clock -> 500 edges.
        fx1_per = 2;
        repeat (2) @(negedge clk);
        en1 = 1'b1;
        push(1, 16'h0500, 1'b0, 1);
        drain(1, 2 * PER1 + 100);
        en1 = 1'b0;

        // Reset on the 5th CONVERT cycle, then a clean measurement.
        fx1_per = 10;
        repeat (3) @(negedge clk);
        nv = nval1;
        en1 = 1'b1;
        repeat (3 + G1 + 4) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        check("t6_freq", int'(freq1), 0);
        check("t6_valid", int'(val1), 0);
        check("t6_ovf", int'(ovf1), 0);
        check("t6_no_valid", nval1 - nv, 0);
        rst1 = 1'b0;
        t0 = pcnt;
        push(1, 16'h0100, 1'b0, 1);
        drain(1, 2 * PER1 + 100);
        if (vt1.size() > 0) check("t6_latency", vt1[$] - t0, LAT1);

        // En dropped mid-gate for 50 cycles.
        repeat (300) @(negedge clk);
        en1 = 1'b0;
        nv = nval1;
        repeat (50) @(negedge clk);
        check("t4_no_valid", nval1 - nv, 0);
        check("t4_hold", int'(freq1), 16'h0100);
        t0 = pcnt;
        en1 = 1'b1;
        push(1, 16'h0100, 1'b0, 1);
        drain(1, 2 * PER1 + 100);
        en1 = 1'b0;
        if (vt1.size() > 0) check_range("t4_latency", vt1[$] - t0, LAT1, LAT1 + 20);

        // Single edge rising on the last GATE cycle is counted.
        fx1_per = 0;
        fx1_hold = 1'b0;
        repeat (5) @(negedge clk);
        en1 = 1'b1;
        push(1, 16'h0001, 1'b0, 1);
        repeat (G1) @(posedge clk);
        @(negedge clk);
        fx1_hold = 1'b1;
        drain(1, 2 * PER1);
        en1 = 1'b0;

        // One cycle later it lands in CONVERT and is dropped.
        fx1_hold = 1'b0;
        repeat (5) @(negedge clk);
        en1 = 1'b1;
        push(1, 16'h0000, 1'b0, 1);
        repeat (G1 + 1) @(posedge clk);
        @(negedge clk);
        fx1_hold = 1'b1;
        drain(1, 2 * PER1);
        en1 = 1'b0;
    endtask

    task automatic run_dut2();
        rst2 = 1'b1;
        en2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        fx2_per = 2;
        en2 = 1'b1;
        push(2, 16'h9999, 1'b1, 1);
        drain(2, G2 + 200);
        en2 = 1'b0;
        fx2_per = 10;
        repeat (3) @(negedge clk);
        check("t3_ovf_hold", int'(ovf2), 1);
        en2 = 1'b1;
        push(2, 16'h3000, 1'b0, 1);
        drain(2, G2 + 200);
        en2 = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        @(negedge clk);
        fork
            run_dut1();
            run_dut2();
        join
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
